matmul_frame_host: RTL and testbench

Host-side framing engine for the 2x2 block-multiply UART link: the initiator end of the protocol whose responder sits in the SOC next to the systolic array. On `start` it serializes eight 16-bit operands into an operand frame, sends the trigger byte, then parses the result frame and presents four 16-bit results. It sits between a byte-level UART (or UART model in simulation) and a test controller or bring-up FPGA that acts in place of the PC.

---
 rtl/matmul_frame_host.sv | 122 ++++++++++++
 tb/tb_matmul_frame_host.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_frame_host.sv
// matmul_frame_host: initiator end of the 2x2 block-multiply UART link; sends an operand frame plus trigger, then parses the result frame.
// Optional feature macro HOST_TIMEOUT_EN: abort an RX wait after TIMEOUT_CYCLES cycles without a received byte.
module matmul_frame_host #(
    parameter int          DATA_W         = 16,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [8*DATA_W-1:0] operands_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [4*DATA_W-1:0] results_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ack_o
);
    localparam logic [7:0] SOF     = 8'hFE;
    localparam logic [7:0] EOF     = 8'hFF;
    localparam logic [3:0] TX_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] RX_LAST = 4'(DATA_W / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_SOF, S_TX_PAY, S_TX_TRIG, S_RX_SOF, S_RX_PAY, S_RX_EOF
    } state_t;

    state_t              r_state, w_next;
    logic [8*DATA_W-1:0] r_ops;
    logic [4*DATA_W-1:0] r_stage;
    logic [3:0]          r_idx;
    logic                w_rx_st, w_tx_xfer, w_rx_xfer, w_tmo;

`ifdef HOST_TIMEOUT_EN
    logic [23:0] r_tmo;

    // Idle counter: runs only while waiting in RX states, cleared by any received byte
    always_ff @(posedge CLK) begin
        if (!RESET || !w_rx_st || w_rx_xfer)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 24'd1;
    end

    assign w_tmo = w_rx_st && !w_rx_xfer && (r_tmo == TIMEOUT_CYCLES - 24'd1);
`else
    assign w_tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and handshake outputs; payload bytes go out MSB-first from a shifting shadow copy
    always_comb begin
        w_next     = r_state;
        busy_o     = r_state != S_IDLE;
        tx_valid_o = r_state inside {S_TX_SOF, S_TX_PAY, S_TX_TRIG};
        w_rx_st    = r_state inside {S_RX_SOF, S_RX_PAY, S_RX_EOF};
        rx_ack_o   = w_rx_st;
        w_tx_xfer  = tx_valid_o && tx_ready_i;
        w_rx_xfer  = w_rx_st && rx_valid_i;
        tx_data_o  = r_state == S_TX_SOF  ? SOF :
                     r_state == S_TX_PAY  ? r_ops[8*DATA_W-1 -: 8] :
                     r_state == S_TX_TRIG ? EOF : 8'h00;
        case (r_state)
            S_IDLE:    if (start) w_next = S_TX_SOF;
            S_TX_SOF:  if (w_tx_xfer) w_next = S_TX_PAY;
            S_TX_PAY:  if (w_tx_xfer && r_idx == TX_LAST) w_next = S_TX_TRIG;
            S_TX_TRIG: if (w_tx_xfer) w_next = S_RX_SOF;
            S_RX_SOF:  if (w_rx_xfer && rx_data_i == SOF) w_next = S_RX_PAY;
            S_RX_PAY:  if (w_rx_xfer && r_idx == RX_LAST) w_next = S_RX_EOF;
            S_RX_EOF:  if (w_rx_xfer) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_tmo) w_next = S_IDLE;
    end

    // Datapath: operand shadow, byte index, result staging and the done/error pulses
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_ops     <= '0;
            r_stage   <= '0;
            r_idx     <= '0;
            results_o <= '0;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= w_tmo;
            if (r_state == S_IDLE && start) begin
                r_ops <= operands_i;
                r_idx <= '0;
            end
            if (r_state == S_TX_PAY && w_tx_xfer) begin
                r_ops <= r_ops << 8;
                r_idx <= r_idx + 4'd1;
            end
            if (r_state == S_RX_SOF && w_rx_xfer && rx_data_i == SOF)
                r_idx <= '0;
            if (r_state == S_RX_PAY && w_rx_xfer) begin
                r_stage <= {r_stage[4*DATA_W-9:0], rx_data_i};
                r_idx   <= r_idx + 4'd1;
            end
            if (r_state == S_RX_EOF && w_rx_xfer) begin
                if (rx_data_i == EOF) begin
                    results_o <= r_stage;
                    done_o    <= 1'b1;
                end else begin
                    error_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matmul_frame_host.sv
// tb_matmul_frame_host: randomized bench acting as the responder side of the link, with a matrix-multiply reference model.
// Define HOST_TIMEOUT_EN to also exercise the RX timeout (DUT built with TIMEOUT_CYCLES=100).
module tb_matmul_frame_host;
    typedef logic [7:0] bq_t[$];

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         start = 1'b0;
    logic [127:0] operands_i = '0;
    logic         tx_ready = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         busy_o, done_o, error_o, tx_valid_o, rx_ack_o;
    logic [63:0]  results_o;
    logic [7:0]   tx_data_o;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [63:0]  exp_res = '0;

    always #5 CLK = ~CLK;

    matmul_frame_host #(.DATA_W(16), .TIMEOUT_CYCLES(24'd100)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .operands_i(operands_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .results_o(results_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ack_o(rx_ack_o)
    );

    // Expected operand frame: SOF, eight words high byte first, trigger
    function automatic bq_t exp_tx(input logic [127:0] o);
        bq_t q;
        logic [15:0] w;
        q.push_back(8'hFE);
        for (int k = 0; k < 8; k++) begin
            w = 16'(o >> (16 * (7 - k)));
            q.push_back(w / 256);
            q.push_back(w % 256);
        end
        q.push_back(8'hFF);
        return q;
    endfunction

    // C = A * B for row-major 2x2 matrices, results truncated to 16 bits
    function automatic logic [63:0] mm(input logic [127:0] o);
        logic [15:0] a[4], b[4], c[4];
        for (int k = 0; k < 4; k++) begin
            a[k] = 16'(o >> (16 * (7 - k)));
            b[k] = 16'(o >> (16 * (3 - k)));
        end
        c[0] = a[0] * b[0] + a[1] * b[2];
        c[1] = a[0] * b[1] + a[1] * b[3];
        c[2] = a[2] * b[0] + a[3] * b[2];
        c[3] = a[2] * b[1] + a[3] * b[3];
        return {c[0], c[1], c[2], c[3]};
    endfunction

    function automatic bq_t make_reply(input bit noise, input logic [63:0] r, input logic [7:0] eof);
        bq_t q;
        if (noise) begin
            q.push_back(8'h00);
            q.push_back(8'h55);
            q.push_back(8'hFF);
        end
        q.push_back(8'hFE);
        for (int k = 0; k < 8; k++) q.push_back(8'(r >> (8 * (7 - k))));
        q.push_back(eof);
        return q;
    endfunction

    function automatic int qdiff(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return -1;
        foreach (a[i]) if (a[i] !== b[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic launch(input logic [127:0] o);
        operands_i = o;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        operands_i = rnd128();
    endtask

    task automatic collect_tx(input bit bp, output bq_t got, output int cyc, output int uns);
        logic [7:0] held;
        bit hv;
        got = {};
        cyc = 0;
        uns = 0;
        hv = 1'b0;
        held = 8'h00;
        while (got.size() < 18 && cyc < 1000) begin
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hv && (tx_valid_o !== 1'b1 || tx_data_o !== held)) uns++;
            hv = 1'b0;
            if (tx_valid_o && tx_ready) got.push_back(tx_data_o);
            else if (tx_valid_o) begin
                hv = 1'b1;
                held = tx_data_o;
            end
            @(negedge CLK);
            cyc++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic send_rx(input bq_t bs, output int to);
        to = 0;
        foreach (bs[i]) begin
            int n = 0;
            rx_data = bs[i];
            rx_valid = 1'b1;
            while (rx_ack_o !== 1'b1 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 100) to++;
            else @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({busy_o, done_o, error_o, tx_valid_o, rx_ack_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, error_o, tx_valid_o, rx_ack_o});
        end
        n_cmp++;
        if (results_o !== 64'h0 || tx_data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h/%h want 0/00", results_o, tx_data_o);
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_nominal;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, to, d;
        o = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        launch(o);
        n_cmp++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hFE) begin
            n_bad++;
            $display("FAIL first_byte: got v=%b d=%h want v=1 d=fe", tx_valid_o, tx_data_o);
        end
        collect_tx(1'b0, got, cyc, uns);
        d = qdiff(got, exp_tx(o));
        n_cmp++;
        if (d != 0) begin
            n_bad++;
            $display("FAIL nominal_stream: diff at %0d (size %0d) want 0", d, got.size());
        end
        n_cmp++;
        if (cyc != 18) begin
            n_bad++;
            $display("FAIL nominal_tx_cycles: got %0d want 18", cyc);
        end
        n_cmp++;
        if (rx_ack_o !== 1'b1 || tx_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_entry: got ack=%b valid=%b want 1/0", rx_ack_o, tx_valid_o);
        end
        start = 1'b1;
        operands_i = rnd128();
        @(negedge CLK);
        start = 1'b0;
        exp_res = 64'h0013_0016_002B_0032;
        send_rx(make_reply(1'b0, exp_res, 8'hFF), to);
        n_cmp++;
        if (to != 0 || done_o !== 1'b1 || error_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_done: got to=%0d done=%b err=%b busy=%b want 0/1/0/0", to, done_o, error_o, busy_o);
        end
        n_cmp++;
        if (results_o !== exp_res) begin
            n_bad++;
            $display("FAIL nominal_results: got %h want %h", results_o, exp_res);
        end
        @(negedge CLK);
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse_or_busy_start: got done=%b busy=%b want 0/0", done_o, busy_o);
        end
    endtask

    task automatic test_bad_eof;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, to;
        o = rnd128();
        launch(o);
        collect_tx(1'b0, got, cyc, uns);
        send_rx(make_reply(1'b0, mm(o), 8'h00), to);
        n_cmp++;
        if (to != 0 || error_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_eof_flags: got to=%0d err=%b done=%b busy=%b want 0/1/0/0", to, error_o, done_o, busy_o);
        end
        n_cmp++;
        if (results_o !== exp_res) begin
            n_bad++;
            $display("FAIL bad_eof_results: got %h want %h", results_o, exp_res);
        end
        @(negedge CLK);
        n_cmp++;
        if (error_o !== 1'b0) begin
            n_bad++;
            $display("FAIL error_pulse: got %b want 0", error_o);
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, to, d;
        o = rnd128();
        launch(o);
        collect_tx(1'b1, got, cyc, uns);
        d = qdiff(got, exp_tx(o));
        n_cmp++;
        if (d != 0) begin
            n_bad++;
            $display("FAIL bp_stream: diff at %0d want 0", d);
        end
        n_cmp++;
        if (uns != 0) begin
            n_bad++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", uns);
        end
        exp_res = mm(o);
        send_rx(make_reply(1'b0, exp_res, 8'hFF), to);
        n_cmp++;
        if (to != 0 || done_o !== 1'b1 || results_o !== exp_res) begin
            n_bad++;
            $display("FAIL bp_results: got to=%0d done=%b res=%h want 0/1/%h", to, done_o, results_o, exp_res);
        end
    endtask

    task automatic test_noise;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, to;
        o = rnd128();
        launch(o);
        collect_tx(1'b0, got, cyc, uns);
        exp_res = mm(o);
        exp_res[63:48] = 16'hFEFF;
        send_rx(make_reply(1'b1, exp_res, 8'hFF), to);
        n_cmp++;
        if (to != 0 || done_o !== 1'b1 || error_o !== 1'b0 || results_o !== exp_res) begin
            n_bad++;
            $display("FAIL noise_results: got to=%0d done=%b err=%b res=%h want 0/1/0/%h", to, done_o, error_o, results_o, exp_res);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] o;
        bq_t got, part;
        int cyc, uns, to;
        o = rnd128();
        launch(o);
        collect_tx(1'b0, got, cyc, uns);
        part = make_reply(1'b0, mm(o), 8'hFF);
        part = part[0:4];
        send_rx(part, to);
        RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({busy_o, done_o, error_o, tx_valid_o, rx_ack_o} !== 5'b0 || results_o !== 64'h0 || tx_data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid: got flags=%b res=%h tx=%h want 00000/0/00",
                     {busy_o, done_o, error_o, tx_valid_o, rx_ack_o}, results_o, tx_data_o);
        end
        RESET = 1'b1;
        exp_res = '0;
        @(negedge CLK);
        o = rnd128();
        launch(o);
        collect_tx(1'b1, got, cyc, uns);
        exp_res = mm(o);
        send_rx(make_reply(1'b0, exp_res, 8'hFF), to);
        n_cmp++;
        if (to != 0 || done_o !== 1'b1 || results_o !== exp_res) begin
            n_bad++;
            $display("FAIL after_reset_txn: got to=%0d done=%b res=%h want 0/1/%h", to, done_o, results_o, exp_res);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, to, d;
        for (int t = 0; t < 5; t++) begin
            o = rnd128();
            launch(o);
            n_cmp++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hFE) begin
                n_bad++;
                $display("FAIL b2b_start[%0d]: got v=%b d=%h want 1/fe", t, tx_valid_o, tx_data_o);
            end
            collect_tx(1'($urandom_range(0, 1)), got, cyc, uns);
            d = qdiff(got, exp_tx(o));
            n_cmp++;
            if (d != 0 || uns != 0) begin
                n_bad++;
                $display("FAIL b2b_stream[%0d]: got diff=%0d unstable=%0d want 0/0", t, d, uns);
            end
            exp_res = mm(o);
            send_rx(make_reply(1'($urandom_range(0, 1)), exp_res, 8'hFF), to);
            n_cmp++;
            if (to != 0 || done_o !== 1'b1 || results_o !== exp_res) begin
                n_bad++;
                $display("FAIL b2b_results[%0d]: got to=%0d done=%b res=%h want 0/1/%h", t, to, done_o, results_o, exp_res);
            end
        end
        @(negedge CLK);
    endtask

`ifdef HOST_TIMEOUT_EN
    task automatic test_timeout;
        logic [127:0] o;
        bq_t got;
        int cyc, uns, k;
        bit busy_mid;
        o = rnd128();
        launch(o);
        collect_tx(1'b0, got, cyc, uns);
        k = 0;
        busy_mid = 1'b0;
        while (error_o !== 1'b1 && k < 300) begin
            start = k < 50;
            @(negedge CLK);
            k++;
            if (k == 50) busy_mid = busy_o;
        end
        start = 1'b0;
        n_cmp++;
        if (k != 100) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d want 100", k);
        end
        n_cmp++;
        if (busy_mid !== 1'b1 || busy_o !== 1'b0 || results_o !== exp_res) begin
            n_bad++;
            $display("FAIL timeout_state: got busy50=%b busy=%b res=%h want 1/0/%h", busy_mid, busy_o, results_o, exp_res);
        end
        @(negedge CLK);
        n_cmp++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: got err=%b busy=%b want 0/0", error_o, busy_o);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_nominal;
        test_bad_eof;
        test_backpressure;
        test_noise;
        test_reset_mid;
        test_back_to_back;
`ifdef HOST_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
